pwm_capture: RTL and testbench

- Measures an incoming PWM waveform on the robot's PMOD pins. It is the reading end of the motor PWM path.
- Reports, once per completed PWM cycle:
  - period in clk cycles;
  - high time in clk cycles;
  - 10-bit duty on the same 0..1023 scale the motor PWM generator accepts.
- Used to loop back motor PWM for self-test and to read PWM-style sensors.
- Detects stuck-high and stuck-low lines via a timeout.

---
 rtl/pwm_capture_pkg.sv | 20 ++
 rtl/pwm_duty_div.sv | 75 +++++++
 rtl/pwm_capture.sv | 164 ++++++++++++++++
 tb/tb_pwm_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module : pwm_capture_pkg
// Brief  : Shared state type and constants for the PWM capture path.
// Rev    : 1.0 - initial release
// ============================================================================
package pwm_capture_pkg;

    localparam int CLK_HZ     = 100_000_000;
    // Duty resolution shared with the motor PWM generator.
    localparam int PWM_DUTY_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_div.sv
`default_nettype none
// ============================================================================
// Module : pwm_duty_div
// Brief  : Restoring unsigned divider producing floor(num * 2^DUTY_W / den).
// Rev    : 1.0 - initial release
// ============================================================================
module pwm_duty_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int DUTY_W = PWM_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  num_i,
    input  logic [CNT_W-1:0]  den_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DUTY_W-1:0] quot_o
);

    localparam int IT_W = $clog2(DUTY_W + 1);
    localparam logic [IT_W-1:0] C_LAST = IT_W'(DUTY_W);

    logic [CNT_W:0]    rem_q;
    logic [CNT_W-1:0]  den_q;
    logic [DUTY_W-1:0] quot_q;
    logic [IT_W-1:0]   iter_q;
    logic              busy_q;

    logic [CNT_W:0]    w_shift;
    logic [CNT_W:0]    w_diff;
    logic              w_ge;

    // num < den is guaranteed by the caller, so the remainder never needs
    // more than one guard bit and the quotient never saturates.
    assign w_shift = rem_q << 1;
    assign w_ge    = (w_shift >= {1'b0, den_q});
    assign w_diff  = w_shift - {1'b0, den_q};

    assign busy_o = busy_q;
    assign done_o = busy_q && (iter_q == C_LAST);
    assign quot_o = quot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            iter_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= {1'b0, num_i};
            den_q  <= den_i;
            quot_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (done_o) begin
                busy_q <= 1'b0;
            end else begin
                rem_q  <= w_ge ? w_diff : w_shift;
                quot_q <= {quot_q[DUTY_W-2:0], w_ge};
                iter_q <= iter_q + IT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module : pwm_capture
// Brief  : Measures period, high time and duty of a PWM input; flags stuck lines.
// Rev    : 1.0 - initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int DUTY_W  = PWM_DUTY_W,
    parameter int TIMEOUT = CLK_HZ / 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  period,
    output logic [CNT_W-1:0]  high_time,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck_high,
    output logic              stuck_low,
    output logic              busy
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic              sync1_q, sync2_q, sync3_q;
    cap_state_t        state_q;
    logic [CNT_W-1:0]  cnt_per_q, cnt_hi_q, hi_lat_q, idle_cnt_q;
    logic [CNT_W-1:0]  launch_per_q, launch_hi_q;
    logic [CNT_W-1:0]  period_q, high_time_q;
    logic [DUTY_W-1:0] duty_q;
    logic              valid_q, stuck_high_q, stuck_low_q;

    logic              w_rise, w_fall;
    logic              w_to_high, w_to_low, w_timeout;
    logic              w_idle_en, w_start;
    logic              w_div_busy, w_div_done;
    logic [DUTY_W-1:0] w_div_quot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign w_rise    = sync2_q & ~sync3_q;
    assign w_fall    = ~sync2_q & sync3_q;
    assign w_to_high = (state_q == ST_HIGH) && (cnt_hi_q == C_TIMEOUT);
    assign w_to_low  = (state_q != ST_HIGH) && (idle_cnt_q == C_TIMEOUT);
    assign w_timeout = w_to_high | w_to_low;
    // Once a stuck flag is up, only a rising edge re-arms; this keeps the
    // stuck report to a single valid pulse.
    assign w_idle_en = (state_q != ST_HIGH) && !sync2_q && !stuck_high_q && !stuck_low_q;
    assign w_start   = (state_q == ST_LOW) && w_rise && !w_div_busy && !w_timeout;

    pwm_duty_div #(
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (w_start),
        .abort_i (w_timeout),
        .num_i   (hi_lat_q),
        .den_i   (cnt_per_q),
        .busy_o  (w_div_busy),
        .done_o  (w_div_done),
        .quot_o  (w_div_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_per_q    <= '0;
            cnt_hi_q     <= '0;
            hi_lat_q     <= '0;
            idle_cnt_q   <= '0;
            launch_per_q <= '0;
            launch_hi_q  <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            idle_cnt_q <= (w_idle_en && !w_timeout) ? idle_cnt_q + C_ONE : '0;

            if (w_timeout) begin
                // Timeout overrides any divider completion in the same cycle.
                state_q      <= ST_IDLE;
                period_q     <= '0;
                high_time_q  <= '0;
                duty_q       <= w_to_high ? '1 : '0;
                valid_q      <= 1'b1;
                stuck_high_q <= w_to_high;
                stuck_low_q  <= w_to_low;
            end else begin
                if (w_div_done) begin
                    period_q    <= launch_per_q;
                    high_time_q <= launch_hi_q;
                    duty_q      <= w_div_quot;
                    valid_q     <= 1'b1;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (w_rise) begin
                            state_q      <= ST_HIGH;
                            cnt_per_q    <= C_ONE;
                            cnt_hi_q     <= C_ONE;
                            stuck_high_q <= 1'b0;
                            stuck_low_q  <= 1'b0;
                        end
                    end
                    ST_HIGH: begin
                        cnt_per_q <= cnt_per_q + C_ONE;
                        cnt_hi_q  <= cnt_hi_q + C_ONE;
                        if (w_fall) begin
                            hi_lat_q <= cnt_hi_q;
                            state_q  <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            if (w_start) begin
                                launch_per_q <= cnt_per_q;
                                launch_hi_q  <= hi_lat_q;
                            end
                            state_q      <= ST_HIGH;
                            cnt_per_q    <= C_ONE;
                            cnt_hi_q     <= C_ONE;
                            stuck_high_q <= 1'b0;
                            stuck_low_q  <= 1'b0;
                        end else begin
                            cnt_per_q <= cnt_per_q + C_ONE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign duty       = duty_q;
    assign valid      = valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;
    assign busy       = w_div_busy;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_pwm_capture
// Brief  : Directed scoreboard bench for pwm_capture.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int TO  = 5000;
    localparam int LAT = 14;   // pin drive to valid sample: 3 sync/detect + DUTY_W+1

    typedef struct {
        int unsigned per;
        int unsigned hi;
        int unsigned duty;
        bit          sh;
        bit          sl;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [31:0] period, high_time;
    logic [9:0]  duty;
    logic        valid, stuck_high, stuck_low, busy;

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    exp_t        sb[$];

    bit          open = 1'b0;
    int unsigned prev_hi = 0, prev_lo = 0;

    pwm_capture #(
        .CNT_W   (32),
        .DUTY_W  (10),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .duty       (duty),
        .valid      (valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_meas(input int unsigned hi, input int unsigned lo);
        exp_t   e;
        longint num;
        num    = longint'(hi) * 1024;
        e.per  = hi + lo;
        e.hi   = hi;
        e.duty = int'(num / longint'(hi + lo));
        e.sh   = 1'b0;
        e.sl   = 1'b0;
        e.due  = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic push_stuck(input bit high);
        exp_t e;
        e.per  = 0;
        e.hi   = 0;
        e.duty = high ? 1023 : 0;
        e.sh   = high;
        e.sl   = !high;
        e.due  = -1;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge where the next rise would go.
    task automatic run(input int unsigned hi, input int unsigned lo, input int n);
        for (int k = 0; k < n; k++) begin
            pwm_in = 1'b1;
            if (open) push_meas(prev_hi, prev_lo);
            open    = 1'b1;
            prev_hi = hi;
            prev_lo = lo;
            repeat (hi) @(negedge clk);
            pwm_in = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("period", period, e.per);
                chk("high_time", high_time, e.hi);
                chk("duty", duty, e.duty);
                chk("stuck_high_at_valid", stuck_high, e.sh);
                chk("stuck_low_at_valid", stuck_low, e.sl);
                if (e.due >= 0) chk("latency", cyc, e.due);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_period", period, 0);
        chk("rst_high_time", high_time, 0);
        chk("rst_duty", duty, 0);
        chk("rst_flags", {valid, stuck_high, stuck_low, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(2000, 2001, 4);   // 50 % loopback
        run(1000, 3001, 3);   // 25 %
        run(6, 10, 6);        // short period
        run(4, 8, 6);         // minimum measurable period

        // Stuck low
        push_stuck(1'b0);
        open = 1'b0;
        repeat (TO + 60) @(negedge clk);
        chk("stuck_low_set", stuck_low, 1);
        chk("stuck_low_period", period, 0);
        run(100, 100, 1);
        chk("stuck_low_clear", stuck_low, 0);

        // Stuck high
        pwm_in = 1'b1;
        if (open) push_meas(prev_hi, prev_lo);
        push_stuck(1'b1);
        open = 1'b0;
        repeat (TO + 60) @(negedge clk);
        chk("stuck_high_set", stuck_high, 1);
        chk("stuck_high_duty", duty, 1023);
        pwm_in = 1'b0;
        repeat (40) @(negedge clk);
        chk("stuck_high_hold_after_fall", stuck_high, 1);
        run(300, 200, 3);
        chk("stuck_high_clear", stuck_high, 0);

        // Reset while the divider is running
        run(50, 50, 1);
        pwm_in = 1'b1;   // closes a cycle whose result the reset discards
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_period", period, 0);
        chk("midrst_high_time", high_time, 0);
        chk("midrst_duty", duty, 0);
        chk("midrst_flags", {valid, stuck_high, stuck_low, busy}, 0);
        pwm_in = 1'b0;
        open   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(30, 20, 3);

        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
